ddr2_init_seq: RTL
==================

# ddr2_init_seq

Power-up initialization sequencer for the DDR2 DIMM command bus. After `start_i` it drives the JEDEC DDR2 init sequence onto the shared CKE/CS#/RAS#/CAS#/WE#/BA/ADDR bus, in order: power-up wait, CKE high, PRECHARGE ALL, EMRS2, EMRS3, EMRS1, MRS with DLL reset, PRECHARGE ALL, 2×REFRESH, final MRS, optional OCD. It then raises `done_o`, and the main controller takes ownership of the command bus. It sits between the reset/clock logic and the controller's command mux.

## Interface
- `T_INIT`, 40000: clocks with CKE low after start (200 µs).
- `T_XPR`, 80: clocks from CKE high to first command (400 ns).
- `T_RP`, 3: clocks after PRECHARGE ALL.
- `T_MRD`, 2: clocks after any (E)MRS.
- `T_RFC`, 26: clocks after REFRESH.
- `T_DLL`, 200: minimum clocks from the DLL-reset MRS to `done_o`.
- `MR_VAL`, 0x042: MR image (BL4, sequential, CL4). A13..A0 beyond `DRAM_ADDR_WIDTH` are dropped.
- `EMR_VAL`, 0x000: EMR1 image (DLL enable, ODT off, OCD exit).
- `clk` in 1: controller clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: begin sequence; sampled only in IDLE.
- `cke_o` in 1→out 1: clock enable to DIMM.
- `cs_n_o`, `ras_n_o`, `cas_n_o`, `we_n_o` out 1 each: command pins.
- `ba_o` out `DRAM_BA_WIDTH`: bank address / mode-register select.
- `addr_o` out `DRAM_ADDR_WIDTH`: address / mode-register payload.
- `busy_o` out 1: sequence in progress.
- `done_o` out 1: init complete; sticky until reset.

## Operation
- Reset values:
  - `cke_o`=0, `cs_n_o`=1 (DESELECT), `ras_n_o`/`cas_n_o`/`we_n_o`=1.
  - `ba_o`=0, `addr_o`=0, `busy_o`=0, `done_o`=0.
  - State IDLE, all counters 0.
- Command encodings, each driven for exactly one cycle. NOP (cs_n,ras_n,cas_n,we_n = 0111) is driven on every other cycle while busy.
  - PREA: 0010, addr[10]=1, other addr bits 0, ba=0.
  - MRS/EMRS: 0000.
    - ba=0 MR, 1 EMR1, 2 EMR2, 3 EMR3.
    - addr = image (EMR2/EMR3 images are 0).
  - REFRESH: 0001.
- State sequence (terminal DONE is exited only by reset):
  - IDLE → PWR_WAIT → XPR_WAIT → PREA1 → EMRS2 → EMRS3 → EMRS1 → MRS_DLLRST → PREA2 → REF1 → REF2 → MRS_FINAL → [OCD_DEF → OCD_EXIT] → FIN_WAIT → DONE.
- IDLE: `start_i`=1 moves to PWR_WAIT and sets `busy_o`.
  - `start_i` is ignored in every other state.
- PWR_WAIT: CKE low, bus NOP, for T_INIT cycles.
- XPR_WAIT: CKE goes high on entry and stays high for the rest of the sequence.
- Command states: gap to the next command = T_RP (PREA), T_MRD ((E)MRS) or T_RFC (REFRESH), counted from the issuing cycle.
- MRS_DLLRST: addr = MR_VAL | bit8.
- MRS_FINAL: addr = MR_VAL (bit8 clear).
- DLL counter: loaded with T_DLL on the MRS_DLLRST cycle, decrements independently of the command timer.
- FIN_WAIT: waits until both the last T_MRD gap and the DLL counter have expired.
- DONE: `done_o`=1, `busy_o`=0, bus DESELECT (cs_n=1), `cke_o` stays 1.
- Reset asserted mid-sequence: all outputs return to reset values asynchronously (CKE drops), state IDLE. A new `start_i` is required.
- Counters are 16 bits. A timing parameter of 0 is treated as 1.

## Timing
- `start_i` high at edge N: `busy_o`=1 and PWR_WAIT at N+1.
- `cke_o` rises at N+1+T_INIT.
- PREA1 is driven T_XPR cycles after `cke_o` rises.
- From PREA1 at cycle t0, with parameters T_RP=3, T_MRD=2, T_RFC=8, T_DLL=20:
  - EMRS2 t0+3, EMRS3 t0+5, EMRS1 t0+7, MRS_DLLRST t0+9.
  - PREA2 t0+11, REF1 t0+14, REF2 t0+22, MRS_FINAL t0+30.
- Without OCD, `done_o`=1 at the later of MRS_FINAL+T_MRD and MRS_DLLRST+T_DLL.
- `done_o` and `busy_o` change on the same edge.

## Configuration
- `DDR2_INIT_OCD_EN` defined:
  - OCD_DEF drives EMRS1 with addr = EMR_VAL | (7<<7).
  - OCD_EXIT then drives EMRS1 with addr = EMR_VAL & ~(7<<7).
  - Each is followed by a T_MRD gap.
- Not defined: MRS_FINAL goes straight to FIN_WAIT; OCD states are not present in RTL.

## Test plan
- Reset, then no start for 100 cycles → `cke_o`=0, `cs_n_o`=1, `busy_o`=0, `done_o`=0 throughout.
- T_INIT=10, T_XPR=4, start at cycle 0:
  - `busy_o`=1 at cycle 1, `cke_o` rises at cycle 11.
  - PREA1 (0010, addr=0x400) at cycle 15.
- Same run (T_RP=3, T_MRD=2, T_RFC=8, T_DLL=20, MR_VAL=0x042), commands relative to PREA1 at cycle 15:
  - EMRS2 +3, EMRS3 +5, EMRS1 +7, MRS ba=0 addr=0x142 at +9.
  - PREA +11, REF +14, REF +22, MRS addr=0x042 at +30.
  - No OCD: `done_o`=1 at +32.
- With `DDR2_INIT_OCD_EN`:
  - EMRS1 addr=0x380 at +32, EMRS1 addr=0x000 at +34.
  - `done_o` at +36.
- T_DLL=40, no OCD → `done_o` delayed to +49 (DLL counter dominates).
- `rst_n` pulsed low at cycle +12 (mid-sequence) → `cke_o`=0 and bus DESELECT immediately.
  - `start_i` pulses while busy are ignored.
  - A new `start_i` replays the full sequence.

Source files
------------

// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialization sequencer.
// Drives the JEDEC init command stream onto the DIMM command bus after
// start_i. When done_o rises, the main controller takes the bus.
// Optional build macro: DDR2_INIT_OCD_EN adds the OCD default/exit EMRS1 pair
// after the final MRS. Without it the OCD states are not built.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | bus deselected, CKE low, waiting for start_i
// PWR_WAIT   | CKE low, NOP, T_INIT clocks
// XPR_WAIT   | CKE high, NOP, T_XPR clocks before first command
// PREA1      | PRECHARGE ALL, then T_RP gap
// EMRS2      | load EMR2 (zero image), then T_MRD gap
// EMRS3      | load EMR3 (zero image), then T_MRD gap
// EMRS1      | load EMR1 image, then T_MRD gap
// MRS_DLLRST | load MR with DLL reset, starts DLL lock counter
// PREA2      | PRECHARGE ALL, then T_RP gap
// REF1       | REFRESH, then T_RFC gap
// REF2       | REFRESH, then T_RFC gap
// MRS_FINAL  | load MR without DLL reset, then T_MRD gap
// OCD_DEF    | EMRS1 with OCD default bits (OCD build only)
// OCD_EXIT   | EMRS1 with OCD exit (OCD build only)
// FIN_WAIT   | wait for last T_MRD gap and DLL counter to expire
// DONE       | done_o high, bus deselected, CKE high; left only by reset

module ddr2_init_seq #(
  parameter int          T_INIT          = 40000,
  parameter int          T_XPR           = 80,
  parameter int          T_RP            = 3,
  parameter int          T_MRD           = 2,
  parameter int          T_RFC           = 26,
  parameter int          T_DLL           = 200,
  parameter int          DRAM_BA_WIDTH   = 2,
  parameter int          DRAM_ADDR_WIDTH = 14,
  parameter logic [13:0] MR_VAL          = 14'h042,
  parameter logic [13:0] EMR_VAL         = 14'h000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  output logic                       cke_o,
  output logic                       cs_n_o,
  output logic                       ras_n_o,
  output logic                       cas_n_o,
  output logic                       we_n_o,
  output logic [DRAM_BA_WIDTH-1:0]   ba_o,
  output logic [DRAM_ADDR_WIDTH-1:0] addr_o,
  output logic                       busy_o,
  output logic                       done_o
);

  // A state lasting T clocks loads T-1; zero or negative T behaves as 1.
  function automatic logic [15:0] ld_val(input int t);
    ld_val = (t <= 1) ? 16'd0 : 16'(t - 1);
  endfunction

  localparam logic [15:0] LD_INIT = ld_val(T_INIT);
  localparam logic [15:0] LD_XPR  = ld_val(T_XPR);
  localparam logic [15:0] LD_RP   = ld_val(T_RP);
  localparam logic [15:0] LD_MRD  = ld_val(T_MRD);
  localparam logic [15:0] LD_RFC  = ld_val(T_RFC);
  localparam logic [15:0] LD_DLL  = ld_val(T_DLL);

  // Mode-register payloads; bits above the DIMM address width are dropped.
  localparam logic [DRAM_ADDR_WIDTH-1:0] A_PREA    = DRAM_ADDR_WIDTH'(14'h0400);
  localparam logic [DRAM_ADDR_WIDTH-1:0] A_MR_DLL  = DRAM_ADDR_WIDTH'(MR_VAL | 14'h0100);
  localparam logic [DRAM_ADDR_WIDTH-1:0] A_MR      = DRAM_ADDR_WIDTH'(MR_VAL & ~14'h0100);
  localparam logic [DRAM_ADDR_WIDTH-1:0] A_EMR     = DRAM_ADDR_WIDTH'(EMR_VAL);
`ifdef DDR2_INIT_OCD_EN
  localparam logic [DRAM_ADDR_WIDTH-1:0] A_OCD_DEF = DRAM_ADDR_WIDTH'(EMR_VAL | 14'h0380);
  localparam logic [DRAM_ADDR_WIDTH-1:0] A_OCD_EXT = DRAM_ADDR_WIDTH'(EMR_VAL & ~14'h0380);
`endif

  localparam logic [DRAM_BA_WIDTH-1:0] BA_MR   = DRAM_BA_WIDTH'(2'd0);
  localparam logic [DRAM_BA_WIDTH-1:0] BA_EMR1 = DRAM_BA_WIDTH'(2'd1);
  localparam logic [DRAM_BA_WIDTH-1:0] BA_EMR2 = DRAM_BA_WIDTH'(2'd2);
  localparam logic [DRAM_BA_WIDTH-1:0] BA_EMR3 = DRAM_BA_WIDTH'(2'd3);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PREA  = 4'b0010;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  typedef enum logic [3:0] {
    IDLE,
    PWR_WAIT,
    XPR_WAIT,
    PREA1,
    EMRS2,
    EMRS3,
    EMRS1,
    MRS_DLLRST,
    PREA2,
    REF1,
    REF2,
    MRS_FINAL,
`ifdef DDR2_INIT_OCD_EN
    OCD_DEF,
    OCD_EXIT,
`endif
    FIN_WAIT,
    DONE
  } state_t;

  state_t      state_q, state_d, succ;
  logic        advance;
  logic [15:0] tmr_q, tmr_d;
  logic [15:0] dll_q, dll_d;
  logic        tmr_zero, dll_zero;

  logic [3:0]                 cmd_d;
  logic [DRAM_BA_WIDTH-1:0]   ba_d;
  logic [DRAM_ADDR_WIDTH-1:0] addr_d;
  logic                       cke_d, busy_d, done_d;

  assign tmr_zero = (tmr_q == 16'd0);
  assign dll_zero = (dll_q == 16'd0);

  // Successor state and the condition that moves the FSM to it.
  always_comb begin
    succ    = state_q;
    advance = 1'b0;
    unique case (state_q)
      IDLE:       begin succ = PWR_WAIT;   advance = start_i;  end
      PWR_WAIT:   begin succ = XPR_WAIT;   advance = tmr_zero; end
      XPR_WAIT:   begin succ = PREA1;      advance = tmr_zero; end
      PREA1:      begin succ = EMRS2;      advance = tmr_zero; end
      EMRS2:      begin succ = EMRS3;      advance = tmr_zero; end
      EMRS3:      begin succ = EMRS1;      advance = tmr_zero; end
      EMRS1:      begin succ = MRS_DLLRST; advance = tmr_zero; end
      MRS_DLLRST: begin succ = PREA2;      advance = tmr_zero; end
      PREA2:      begin succ = REF1;       advance = tmr_zero; end
      REF1:       begin succ = REF2;       advance = tmr_zero; end
      REF2:       begin succ = MRS_FINAL;  advance = tmr_zero; end
`ifdef DDR2_INIT_OCD_EN
      MRS_FINAL:  begin succ = OCD_DEF;    advance = tmr_zero; end
      OCD_DEF:    begin succ = OCD_EXIT;   advance = tmr_zero; end
      // Last command: its T_MRD gap keeps running in FIN_WAIT.
      OCD_EXIT: begin
        succ    = (tmr_zero && dll_zero) ? DONE : FIN_WAIT;
        advance = 1'b1;
      end
`else
      // Last command: its T_MRD gap keeps running in FIN_WAIT.
      MRS_FINAL: begin
        succ    = (tmr_zero && dll_zero) ? DONE : FIN_WAIT;
        advance = 1'b1;
      end
`endif
      FIN_WAIT:   begin succ = DONE;       advance = tmr_zero && dll_zero; end
      DONE:       begin succ = DONE;       advance = 1'b0; end
      default:    begin succ = IDLE;       advance = 1'b1; end
    endcase
    state_d = advance ? succ : state_q;
  end

  // Command timer and DLL lock counter: free-running down-counters,
  // reloaded on entry into the state that owns them.
  always_comb begin
    tmr_d = tmr_zero ? 16'd0 : tmr_q - 16'd1;
    dll_d = dll_zero ? 16'd0 : dll_q - 16'd1;
    if (advance) begin
      unique case (succ)
        PWR_WAIT:                         tmr_d = LD_INIT;
        XPR_WAIT:                         tmr_d = LD_XPR;
        PREA1, PREA2:                     tmr_d = LD_RP;
        REF1, REF2:                       tmr_d = LD_RFC;
        EMRS2, EMRS3, EMRS1, MRS_DLLRST,
`ifdef DDR2_INIT_OCD_EN
        OCD_DEF, OCD_EXIT,
`endif
        MRS_FINAL:                        tmr_d = LD_MRD;
        default:                          ;
      endcase
      if (succ == MRS_DLLRST) dll_d = LD_DLL;
    end
  end

  // Next bus image: command on the first cycle of a command state, NOP
  // otherwise while busy, DESELECT when idle or done.
  always_comb begin
    cke_d  = !(state_d inside {IDLE, PWR_WAIT});
    busy_d = !(state_d inside {IDLE, DONE});
    done_d = (state_d == DONE);
    cmd_d  = busy_d ? CMD_NOP : CMD_DESEL;
    ba_d   = '0;
    addr_d = '0;
    if (advance) begin
      unique case (succ)
        PREA1, PREA2: begin cmd_d = CMD_PREA; addr_d = A_PREA; end
        EMRS2:        begin cmd_d = CMD_MRS;  ba_d = BA_EMR2; end
        EMRS3:        begin cmd_d = CMD_MRS;  ba_d = BA_EMR3; end
        EMRS1:        begin cmd_d = CMD_MRS;  ba_d = BA_EMR1; addr_d = A_EMR;    end
        MRS_DLLRST:   begin cmd_d = CMD_MRS;  ba_d = BA_MR;   addr_d = A_MR_DLL; end
        REF1, REF2:   begin cmd_d = CMD_REF; end
        MRS_FINAL:    begin cmd_d = CMD_MRS;  ba_d = BA_MR;   addr_d = A_MR;     end
`ifdef DDR2_INIT_OCD_EN
        OCD_DEF:      begin cmd_d = CMD_MRS;  ba_d = BA_EMR1; addr_d = A_OCD_DEF; end
        OCD_EXIT:     begin cmd_d = CMD_MRS;  ba_d = BA_EMR1; addr_d = A_OCD_EXT; end
`endif
        default:      ;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= 16'd0;
      dll_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dll_q   <= dll_d;
    end
  end

  // Registered command bus so the DIMM sees glitch-free pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cke_o                                  <= 1'b0;
      {cs_n_o, ras_n_o, cas_n_o, we_n_o}     <= CMD_DESEL;
      ba_o                                   <= '0;
      addr_o                                 <= '0;
      busy_o                                 <= 1'b0;
      done_o                                 <= 1'b0;
    end else begin
      cke_o                                  <= cke_d;
      {cs_n_o, ras_n_o, cas_n_o, we_n_o}     <= cmd_d;
      ba_o                                   <= ba_d;
      addr_o                                 <= addr_d;
      busy_o                                 <= busy_d;
      done_o                                 <= done_d;
    end
  end

endmodule
